// File: rtl/boot_ctrl_if.sv
// Programmer-side bundle for boot_ctrl: UART programmer strobes in, programmer reset and
// gated memory write enables out.
interface boot_ctrl_if;
    logic        upg_done_i;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic        upg_rst_o;
    logic        imem_wen_o;
    logic        dmem_wen_o;

    modport master (
        output upg_done_i, upg_wen_i, upg_adr_i,
        input  upg_rst_o, imem_wen_o, dmem_wen_o
    );

    modport slave (
        input  upg_done_i, upg_wen_i, upg_adr_i,
        output upg_rst_o, imem_wen_o, dmem_wen_o
    );
endinterface

// File: rtl/boot_ctrl.sv
// Run/program mode sequencer: debounced start button, programmer write gating, timed CPU reset.
// Optional PROG idle timeout enabled by defining BOOT_CTRL_TIMEOUT_EN.
module boot_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned DRAIN_CYCLES    = 8,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_btn,
    boot_ctrl_if.slave  upg,
    output logic        cpu_rst_o,
    output logic [14:0] word_cnt_o,
    output logic [2:0]  mode_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StHold  = 3'd0,
        StRun   = 3'd1,
        StArm   = 3'd2,
        StProg  = 3'd3,
        StDrain = 3'd4
    } state_e;

    localparam int unsigned CntMax = (RST_HOLD_CYCLES > DRAIN_CYCLES) ? RST_HOLD_CYCLES
                                                                      : DRAIN_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 2);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              btn_meta_q, btn_sync_q;
    logic [DbW-1:0]    db_cnt_q, db_cnt_d;
    logic              start_evt;
    logic [14:0]       word_cnt_q, word_cnt_d;
    logic              cpu_rst_q, upg_rst_q;
    logic              timeout_hit;
    logic              in_prog;
    logic              unused_adr;

    assign in_prog    = (state_q == StProg);
    assign unused_adr = ^upg.upg_adr_i[13:0];

    // Debounce count parks one past the threshold so a held button fires only once.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!btn_sync_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DbW'(DEBOUNCE_CYCLES + 1)) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign start_evt = (db_cnt_q == DbW'(DEBOUNCE_CYCLES));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHold:  if (cnt_q == CntW'(RST_HOLD_CYCLES - 1)) state_d = StRun;
            StRun:   if (start_evt) state_d = StArm;
            StArm:   state_d = StProg;
            // cnt_q is zero only in the first PROG cycle, masking a stale done level
            StProg: begin
                if (upg.upg_done_i && (cnt_q != '0)) begin
                    state_d = StDrain;
                end else if (timeout_hit) begin
                    state_d = StHold;
                end
            end
            StDrain: if (cnt_q == CntW'(DRAIN_CYCLES - 1)) state_d = StHold;
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (state_q == StArm) begin
            word_cnt_d = '0;
        end else if (in_prog && upg.upg_wen_i && (word_cnt_q != 15'h7FFF)) begin
            word_cnt_d = word_cnt_q + 15'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_cnt_q   <= '0;
            word_cnt_q <= '0;
            cpu_rst_q  <= 1'b1;
            upg_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_meta_q <= start_btn;
            btn_sync_q <= btn_meta_q;
            db_cnt_q   <= db_cnt_d;
            word_cnt_q <= word_cnt_d;
            cpu_rst_q  <= (state_d != StRun);
            upg_rst_q  <= (state_d != StProg);
        end
    end

`ifdef BOOT_CTRL_TIMEOUT_EN
    logic [23:0] idle_q, idle_d;
    logic        err_q;

    always_comb begin
        idle_d = idle_q;
        if (state_q == StArm) begin
            idle_d = '0;
        end else if (in_prog) begin
            idle_d = upg.upg_wen_i ? 24'd0 : idle_q + 24'd1;
        end
    end

    assign timeout_hit = in_prog && !upg.upg_wen_i && (idle_q == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            if (in_prog && (state_d == StHold)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
`endif

    assign upg.imem_wen_o = in_prog & upg.upg_wen_i & ~upg.upg_adr_i[14];
    assign upg.dmem_wen_o = in_prog & upg.upg_wen_i & upg.upg_adr_i[14];
    assign upg.upg_rst_o  = upg_rst_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign word_cnt_o     = word_cnt_q;
    assign mode_o         = state_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed self-checking bench for boot_ctrl using parameters 4/8/4/100.
module tb_boot_ctrl;

    logic        clock;
    logic        reset_n;
    logic        start_btn;
    logic        cpu_rst_o;
    logic [14:0] word_cnt_o;
    logic [2:0]  mode_o;
    logic        err_o;
    int          n_checks;
    int          n_errors;

    boot_ctrl_if upg_bus ();

    boot_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RST_HOLD_CYCLES (8),
        .DRAIN_CYCLES    (4),
        .TIMEOUT_CYCLES  (24'd100)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_btn  (start_btn),
        .upg        (upg_bus),
        .cpu_rst_o  (cpu_rst_o),
        .word_cnt_o (word_cnt_o),
        .mode_o     (mode_o),
        .err_o      (err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Press for 6 cycles from RUN; ARM appears 7 edges after the rise, PROG one edge later.
    task automatic run_to_prog();
        start_btn = 1'b1;
        step(6);
        start_btn = 1'b0;
        step();
        check_eq("sess_arm", mode_o, 3'd2);
        step();
        check_eq("sess_prog", mode_o, 3'd3);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start_btn = 1'b0;
        upg_bus.upg_done_i = 1'b0;
        upg_bus.upg_wen_i  = 1'b0;
        upg_bus.upg_adr_i  = 15'h0000;

        step(2);
        check_eq("rst_mode", mode_o, 3'd0);
        check_eq("rst_cpu_rst", cpu_rst_o, 1'b1);
        check_eq("rst_upg_rst", upg_bus.upg_rst_o, 1'b1);
        check_eq("rst_word_cnt", word_cnt_o, 15'd0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_imem_wen", upg_bus.imem_wen_o, 1'b0);
        check_eq("rst_dmem_wen", upg_bus.dmem_wen_o, 1'b0);

        // HOLD for 8 cycles after release, RUN on the 8th edge
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check_eq("hold_mode", mode_o, 3'd0);
            check_eq("hold_cpu_rst", cpu_rst_o, 1'b1);
        end
        step();
        check_eq("run_mode", mode_o, 3'd1);
        check_eq("run_cpu_rst", cpu_rst_o, 1'b0);
        check_eq("run_upg_rst", upg_bus.upg_rst_o, 1'b1);

        // Writes outside PROG are blocked
        upg_bus.upg_wen_i = 1'b1;
        upg_bus.upg_adr_i = 15'h0000;
        #1;
        check_eq("run_imem_gated", upg_bus.imem_wen_o, 1'b0);
        upg_bus.upg_adr_i = 15'h4000;
        #1;
        check_eq("run_dmem_gated", upg_bus.dmem_wen_o, 1'b0);
        upg_bus.upg_wen_i = 1'b0;

        // Short 3-cycle press must not fire
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
        step(8);
        check_eq("short_press_mode", mode_o, 3'd1);

        // 6-cycle press: ARM exactly 7 edges after the rise
        start_btn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check_eq("debounce_run_mode", mode_o, 3'd1);
        end
        start_btn = 1'b0;
        step();
        check_eq("arm_mode", mode_o, 3'd2);
        check_eq("arm_cpu_rst", cpu_rst_o, 1'b1);
        check_eq("arm_upg_rst", upg_bus.upg_rst_o, 1'b1);
        check_eq("arm_word_cnt", word_cnt_o, 15'd0);
        step();
        check_eq("prog_mode", mode_o, 3'd3);
        check_eq("prog_upg_rst", upg_bus.upg_rst_o, 1'b0);
        check_eq("prog_cpu_rst", cpu_rst_o, 1'b1);

        // Three writes: imem, imem, dmem
        upg_bus.upg_wen_i = 1'b1;
        upg_bus.upg_adr_i = 15'h0000;
        #1;
        check_eq("wr0_imem", upg_bus.imem_wen_o, 1'b1);
        check_eq("wr0_dmem", upg_bus.dmem_wen_o, 1'b0);
        step();
        upg_bus.upg_adr_i = 15'h0001;
        #1;
        check_eq("wr1_imem", upg_bus.imem_wen_o, 1'b1);
        check_eq("wr1_dmem", upg_bus.dmem_wen_o, 1'b0);
        step();
        upg_bus.upg_adr_i = 15'h4000;
        #1;
        check_eq("wr2_imem", upg_bus.imem_wen_o, 1'b0);
        check_eq("wr2_dmem", upg_bus.dmem_wen_o, 1'b1);
        step();
        upg_bus.upg_wen_i = 1'b0;
        #1;
        check_eq("wr_idle_imem", upg_bus.imem_wen_o, 1'b0);
        check_eq("wr_idle_dmem", upg_bus.dmem_wen_o, 1'b0);
        check_eq("wr_word_cnt", word_cnt_o, 15'd3);
        check_eq("wr_mode", mode_o, 3'd3);

        // Done together with a write: write counted and gated, DRAIN still entered
        upg_bus.upg_wen_i  = 1'b1;
        upg_bus.upg_adr_i  = 15'h4001;
        upg_bus.upg_done_i = 1'b1;
        #1;
        check_eq("done_wr_dmem", upg_bus.dmem_wen_o, 1'b1);
        step();
        upg_bus.upg_wen_i = 1'b0;
        check_eq("drain_mode", mode_o, 3'd4);
        check_eq("drain_word_cnt", word_cnt_o, 15'd4);
        check_eq("drain_upg_rst", upg_bus.upg_rst_o, 1'b1);
        step(3);
        check_eq("drain_last", mode_o, 3'd4);
        step();
        check_eq("drain_to_hold", mode_o, 3'd0);
        check_eq("drain_hold_cpu_rst", cpu_rst_o, 1'b1);
        step(7);
        check_eq("hold2_last", mode_o, 3'd0);
        step();
        check_eq("run2_mode", mode_o, 3'd1);
        check_eq("run2_cpu_rst", cpu_rst_o, 1'b0);

        // Stale done level on PROG entry, button held through the whole session
        start_btn = 1'b1;
        step(7);
        check_eq("stale_arm", mode_o, 3'd2);
        step();
        check_eq("stale_prog_c1", mode_o, 3'd3);
        check_eq("stale_word_cnt", word_cnt_o, 15'd0);
        step();
        check_eq("stale_prog_c2", mode_o, 3'd3);
        step();
        check_eq("stale_drain_c3", mode_o, 3'd4);
        step(4);
        check_eq("stale_hold", mode_o, 3'd0);
        step(8);
        check_eq("stale_run", mode_o, 3'd1);
        check_eq("stale_run_cpu_rst", cpu_rst_o, 1'b0);
        step(20);
        check_eq("held_no_rearm", mode_o, 3'd1);
        start_btn = 1'b0;
        upg_bus.upg_done_i = 1'b0;
        step(5);

`ifdef BOOT_CTRL_TIMEOUT_EN
        // 100 idle PROG cycles abort to HOLD with a sticky error
        run_to_prog();
        step(99);
        check_eq("to_before_mode", mode_o, 3'd3);
        check_eq("to_before_err", err_o, 1'b0);
        step();
        check_eq("to_mode", mode_o, 3'd0);
        check_eq("to_err", err_o, 1'b1);
        check_eq("to_upg_rst", upg_bus.upg_rst_o, 1'b1);
        step(7);
        check_eq("to_hold_last", mode_o, 3'd0);
        step();
        check_eq("to_run", mode_o, 3'd1);
        check_eq("to_err_sticky", err_o, 1'b1);
        step(5);
`else
        check_eq("no_timeout_err", err_o, 1'b0);
`endif

        // Asynchronous reset mid-PROG during a write
        run_to_prog();
        upg_bus.upg_wen_i = 1'b1;
        upg_bus.upg_adr_i = 15'h0002;
        step();
        check_eq("pre_rst_word_cnt", word_cnt_o, 15'd1);
        check_eq("pre_rst_imem", upg_bus.imem_wen_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_imem", upg_bus.imem_wen_o, 1'b0);
        check_eq("async_dmem", upg_bus.dmem_wen_o, 1'b0);
        check_eq("async_word_cnt", word_cnt_o, 15'd0);
        check_eq("async_mode", mode_o, 3'd0);
        check_eq("async_upg_rst", upg_bus.upg_rst_o, 1'b1);
        check_eq("async_cpu_rst", cpu_rst_o, 1'b1);
        check_eq("async_err", err_o, 1'b0);
        upg_bus.upg_wen_i = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
